// File: rtl/dmem_preload.sv
// dmem_preload: 8 x 8-bit data memory that is preloaded with a constant image.
// After reset, or on a reload request, a sequencer copies D0..D7 into the array
// one word per cycle. While busy is high, CPU writes are ignored. Once the load
// finishes, the CPU reads combinationally and writes synchronously.

// One storage word. It has an async clear and a synchronous write.
module dmem_word #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] q
);
    // The word clears immediately on reset and otherwise loads when selected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      q <= '0;
        else if (wen) q <= wdata;
    end
endmodule

module dmem_preload #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic [WIDTH-1:0] D3,
    input  logic [WIDTH-1:0] D4,
    input  logic [WIDTH-1:0] D5,
    input  logic [WIDTH-1:0] D6,
    input  logic [WIDTH-1:0] D7,
    input  logic [AW-1:0]    addr,
    input  logic             we,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    input  logic             reload,
    output logic             busy,
    output logic             load_done
);
    typedef enum logic {LOAD, IDLE} state_t;

    state_t                        state, state_n;
    logic [AW-1:0]                 idx, idx_n;
    logic                          busy_n, done_n;
    logic                          ld_we, cpu_we;
    logic [DEPTH-1:0][WIDTH-1:0]   d_img;
    logic [DEPTH-1:0][WIDTH-1:0]   mem;

    // Gather the preset image so it can be indexed by word number.
    assign d_img = {D7, D6, D5, D4, D3, D2, D1, D0};

    // State, load index and the registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD;
            idx       <= '0;
            busy      <= 1'b1;
            load_done <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            busy      <= busy_n;
            load_done <= done_n;
        end
    end

    // Sequencer control. Reload takes priority over a CPU write in IDLE.
    // Both reload and we are ignored while loading.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        done_n  = 1'b0;
        ld_we   = 1'b0;
        cpu_we  = 1'b0;
        unique case (state)
            LOAD: begin
                ld_we = 1'b1;
                idx_n = idx + 1'b1;
                if (idx == AW'(DEPTH - 1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            IDLE: begin
                if (reload) begin
                    state_n = LOAD;
                    idx_n   = '0;
                end else if (we) begin
                    cpu_we = 1'b1;
                end
            end
            default: state_n = LOAD;
        endcase
        // busy is registered from the next state so it falls on the edge that enters IDLE.
        busy_n = (state_n == LOAD);
    end

    // Storage array. Each word is written either by the sequencer or by the CPU,
    // and the two write sources are mutually exclusive by state.
    genvar n;
    generate
        for (n = 0; n < DEPTH; n++) begin : g_word
            logic             wen;
            logic [WIDTH-1:0] wdata;
            assign wen   = (ld_we && idx == AW'(n)) || (cpu_we && addr == AW'(n));
            assign wdata = ld_we ? d_img[n] : wr_data;
            dmem_word #(.WIDTH(WIDTH)) u_word (
                .clk   (clk),
                .rst   (rst),
                .wen   (wen),
                .wdata (wdata),
                .q     (mem[n])
            );
        end
    endgenerate

    assign rd_data = mem[addr];
endmodule

// File: tb/tb_dmem_preload.sv
// Directed bench for dmem_preload. It uses hand-computed expectations and checks them with immediate assertions.
module tb_dmem_preload;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] D0, D1, D2, D3, D4, D5, D6, D7;
    logic [2:0] addr;
    logic       we;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       reload;
    logic       busy;
    logic       load_done;

    int n_chk  = 0;
    int n_pass = 0;

    dmem_preload dut (
        .clk(clk), .rst(rst),
        .D0(D0), .D1(D1), .D2(D2), .D3(D3), .D4(D4), .D5(D5), .D6(D6), .D7(D7),
        .addr(addr), .we(we), .wr_data(wr_data), .rd_data(rd_data),
        .reload(reload), .busy(busy), .load_done(load_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one clock edge, then settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count the edges until busy falls (with a bound), and count the load_done pulses,
    // including one cycle after busy falls.
    task automatic wait_load(output int n, output int dn);
        n  = 0;
        dn = 0;
        repeat (20) begin
            step();
            n++;
            if (load_done) dn++;
            if (!busy) break;
        end
        step();
        if (load_done) dn++;
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string tag);
        addr = a;
        #1;
        chk(tag, rd_data, exp);
    endtask

    initial begin
        int n, dn;
        logic [7:0] img [8];
        rst = 1'b1; addr = '0; we = 1'b0; wr_data = '0; reload = 1'b0;
        {D0, D1, D2, D3, D4, D5, D6, D7} = {8'h0A, 8'h01, 48'h0};

        // Reset state, checked before any clock edge.
        #3;
        chk("rst_busy", busy, 1);
        chk("rst_done", load_done, 0);
        chk("rst_rd", rd_data, 0);
        step();
        chk("rst_rd_edge", rd_data, 0);
        rst = 1'b0;

        // Initial load.
        wait_load(n, dn);
        chk("load1_cycles", n, 8);
        chk("load1_done_pulses", dn, 1);
        img = '{8'h0A, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 8; i++) rd(3'(i), img[i], $sformatf("load1_mem%0d", i));

        // CPU write, then read it back. The other words must be unchanged.
        addr = 3; we = 1'b1; wr_data = 8'h22;
        step();
        we = 1'b0;
        img[3] = 8'h22;
        for (int i = 0; i < 8; i++) rd(3'(i), img[i], $sformatf("wr_mem%0d", i));

        // A write during load cycle 4 must be ignored.
        reload = 1'b1;
        step();
        reload = 1'b0;
        chk("reload_busy", busy, 1);
        repeat (3) step();
        addr = 0; we = 1'b1; wr_data = 8'hFF;
        step();
        we = 1'b0;
        wait_load(n, dn);
        chk("ldwr_remaining", n, 4);
        chk("ldwr_done_pulses", dn, 1);
        rd(0, 8'h0A, "ldwr_mem0");
        rd(3, 8'h00, "ldwr_mem3_reloaded");

        // New image. Write addr 1, then reload together with a write that must be dropped.
        {D0, D1, D2, D3, D4, D5, D6, D7} = {8'h22, 8'hA8, 8'h04, 8'h03, 8'h22, 24'h0};
        addr = 1; we = 1'b1; wr_data = 8'h55;
        step();
        we = 1'b0;
        rd(1, 8'h55, "img2_wr55");
        reload = 1'b1; we = 1'b1; addr = 2; wr_data = 8'h77;
        step();
        reload = 1'b0; we = 1'b0;
        chk("img2_busy", busy, 1);
        rd(2, 8'h00, "img2_write_dropped");
        wait_load(n, dn);
        chk("img2_cycles", n, 8);
        chk("img2_done_pulses", dn, 1);
        img = '{8'h22, 8'hA8, 8'h04, 8'h03, 8'h22, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 8; i++) rd(3'(i), img[i], $sformatf("img2_mem%0d", i));

        // Asynchronous reset in the middle of load cycle 5.
        reload = 1'b1;
        step();
        reload = 1'b0;
        repeat (4) step();
        addr = 0;
        #2;
        chk("mid_rd_before", rd_data, 8'h22);
        rst = 1'b1;
        #1;
        chk("async_rd_zero", rd_data, 0);
        chk("async_busy", busy, 1);
        step();
        rst = 1'b0;
        wait_load(n, dn);
        chk("rst_reload_cycles", n, 8);
        chk("rst_reload_done_pulses", dn, 1);
        rd(0, 8'h22, "rst_reload_mem0");
        rd(1, 8'hA8, "rst_reload_mem1");

        // A reload request during LOAD neither restarts nor extends the load.
        reload = 1'b1;
        step();
        reload = 1'b0;
        repeat (3) step();
        reload = 1'b1;
        step();
        reload = 1'b0;
        wait_load(n, dn);
        chk("reload_in_load_remaining", n, 4);
        chk("reload_in_load_done_pulses", dn, 1);
        chk("final_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
